// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - two-master memory/IO bus arbiter with wait states and ready pulses
// Define MIO_RR_EN for round-robin arbitration; otherwise the CPU port has fixed priority.
module mio_bus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              last_grant_q, last_grant_d;
  logic              pick_aux;

  // owner/last_grant encoding: 0 = CPU port, 1 = aux port
`ifdef MIO_RR_EN
  assign pick_aux = m1_req & (~cpu_req | ~last_grant_q);
`else
  assign pick_aux = m1_req & ~cpu_req;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || m1_req) begin
          owner_d = pick_aux;
          we_d    = pick_aux ? m1_we    : cpu_we;
          addr_d  = pick_aux ? m1_addr  : cpu_addr;
          wdata_d = pick_aux ? m1_wdata : cpu_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q) m1_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      m1_rdata_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign mem_cs    = (state_q == S_ACCESS);
  assign mem_we    = mem_cs & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ready = (state_q == S_RESP) & ~owner_q;
  assign m1_ready  = (state_q == S_RESP) & owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign grant     = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule
